// File: rtl/i2c_reg_seq_if.sv
// i2c_reg_seq_if: command/response bus between the register sequencer and the I2C byte master.
interface i2c_reg_seq_if;
  logic       wr;
  logic [2:0] cmd;
  logic [7:0] din;
  logic       ready;
  logic       done_tick;
  logic       ack;
  logic [7:0] dout;
  modport master (output wr, cmd, din, input ready, done_tick, ack, dout);
  modport slave  (input wr, cmd, din, output ready, done_tick, ack, dout);
endinterface

// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns one start pulse into a full I2C register write or STOP-separated register read.
module i2c_reg_seq #(
  parameter logic [2:0]  NOP_CMD     = 3'd7,
  parameter logic [19:0] TIMEOUT_CYC = 20'hFFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       rw_i,
  input  logic [6:0] dev_addr_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       nack_err_o,
  output logic       tout_err_o,
  output logic [7:0] rdata_o,
  i2c_reg_seq_if.master m
);
  localparam logic [2:0] C_START = 3'd0, C_WR = 3'd1, C_RD = 3'd2, C_STOP = 3'd3;
  typedef enum logic [3:0] {IDLE, S_START, W_HOLD, A_W, B_REG, B_DAT, P_STOP, A_R, B_RD, FIN} state_t;
  state_t state_q, state_d, nxt;
  logic [19:0] cnt_q, cnt_d;
  logic seen_q, seen_d, ph2_q, ph2_d, rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d, wd_q, wd_d, din_q, din_d, rdata_q, rdata_d;
  logic busy_q, busy_d, done_q, done_d, nack_q, nack_d, tout_q, tout_d, wr_q, wr_d;
  logic [2:0] cmd_q, cmd_d;
  logic tmo, wbyte;
  // seen_q remembers ready dropping, so a later ready=1 means the master finished START/STOP
  assign seen_d = state_d == state_q && (seen_q || !m.ready);
  assign cnt_d  = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 20'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      ph2_q   <= 1'b0;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      tout_q  <= 1'b0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      cmd_q   <= NOP_CMD;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      ph2_q   <= ph2_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
      tout_q  <= tout_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      cmd_q   <= cmd_d;
      din_q   <= din_d;
    end
  always_comb begin
    nxt = state_q;
    case (state_q)
      IDLE:       nxt = start_i ? S_START : IDLE;
      S_START:    nxt = m.ready ? W_HOLD : S_START;
      W_HOLD:     nxt = (seen_q && m.ready) ? (ph2_q ? A_R : A_W) : W_HOLD;
      A_W:        nxt = m.done_tick ? (m.ack ? P_STOP : B_REG) : A_W;
      B_REG:      nxt = m.done_tick ? ((m.ack || rw_q) ? P_STOP : B_DAT) : B_REG;
      A_R:        nxt = m.done_tick ? (m.ack ? P_STOP : B_RD) : A_R;
      B_DAT, B_RD: nxt = m.done_tick ? P_STOP : state_q;
      P_STOP:     nxt = (seen_q && m.ready) ? ((rw_q && !ph2_q && !nack_q) ? S_START : FIN) : P_STOP;
      default:    nxt = IDLE;
    endcase
    tmo     = state_q != IDLE && state_q != FIN && nxt == state_q && cnt_q == TIMEOUT_CYC - 20'd1;
    state_d = tmo ? FIN : nxt;
  end
  // next cmd/din are loaded on the transition edge so the master's first HOLD cycle already sees them
  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    tout_d  = tout_q;
    wr_d    = 1'b0;
    cmd_d   = state_q == W_HOLD ? NOP_CMD : cmd_q;
    din_d   = din_q;
    ph2_d   = ph2_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wd_d    = wd_q;
    wbyte   = m.done_tick && (state_q == A_W || state_q == B_REG || state_q == B_DAT || state_q == A_R);
    nack_d  = nack_q | (wbyte & m.ack);
    rdata_d = (state_q == B_RD && m.done_tick) ? m.dout : rdata_q;
    if (state_d != state_q)
      case (state_d)
        S_START: begin
          cmd_d = NOP_CMD;
          ph2_d = state_q == P_STOP;
          if (state_q == IDLE) begin
            rw_d   = rw_i;
            dev_d  = dev_addr_i;
            reg_d  = reg_addr_i;
            wd_d   = wdata_i;
            nack_d = 1'b0;
            tout_d = 1'b0;
            busy_d = 1'b1;
          end
        end
        W_HOLD: begin
          wr_d  = 1'b1;
          cmd_d = C_START;
        end
        A_W, A_R: begin
          cmd_d = C_WR;
          din_d = {dev_q, state_d == A_R};
        end
        B_REG:  din_d = reg_q;
        B_DAT:  din_d = wd_q;
        B_RD:   cmd_d = C_RD;
        P_STOP: cmd_d = C_STOP;
        FIN: begin
          done_d = 1'b1;
          busy_d = 1'b0;
          cmd_d  = NOP_CMD;
          tout_d = tmo;
        end
        default: ;
      endcase
  end
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign nack_err_o = nack_q;
  assign tout_err_o = tout_q;
  assign rdata_o    = rdata_q;
  assign m.wr       = wr_q;
  assign m.cmd      = cmd_q;
  assign m.din      = din_q;
endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb_i2c_reg_seq: drives register transactions against a behavioural byte-master/slave model.
module tb_i2c_reg_seq;
  localparam logic [19:0] TMO = 20'd100;
  localparam logic [2:0] C_START = 3'd0, C_WR = 3'd1, C_RD = 3'd2, C_STOP = 3'd3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rw = 1'b0;
  logic [6:0] dev = '0;
  logic [7:0] rg = '0, wd = '0;
  logic busy, done, nack, tout;
  logic [7:0] rdata;
  int checks = 0, failures = 0;
  int done_cnt = 0, wr_cnt = 0;
  logic [7:0] exp_rdata = '0;
  i2c_reg_seq_if bus();
  i2c_reg_seq #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .rw_i(rw), .dev_addr_i(dev),
    .reg_addr_i(rg), .wdata_i(wd), .busy_o(busy), .done_o(done), .nack_err_o(nack),
    .tout_err_o(tout), .rdata_o(rdata), .m(bus.master)
  );
  always #5 clk = ~clk;
  // byte master + slave: 0 idle, 1 start busy, 2 hold, 3 byte busy, 4 done tick, 5 stop busy
  int m_st, m_lat, m_wrn, m_nk = 9;
  logic [7:0] m_rd = '0, m_dout;
  logic m_ack;
  bit tie0 = 1'b0;
  logic [10:0] ev[$];
  assign bus.ready     = !tie0 && (m_st == 0 || m_st == 2);
  assign bus.done_tick = m_st == 4;
  assign bus.ack       = m_ack;
  assign bus.dout      = m_dout;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_st <= 0; m_lat <= 0; m_wrn <= 0; m_ack <= 1'b0; m_dout <= '0;
    end else begin
      if (!busy) m_wrn <= 0;
      case (m_st)
        0: if (!tie0 && bus.wr && bus.cmd == C_START) begin
          ev.push_back({C_START, 8'h00}); m_st <= 1; m_lat <= int'($urandom_range(1, 6));
        end
        1, 3, 5: if (m_lat > 1) m_lat <= m_lat - 1; else m_st <= m_st == 1 ? 2 : m_st == 3 ? 4 : 0;
        2: if (bus.cmd == C_WR) begin
          ev.push_back({C_WR, bus.din}); m_ack <= m_wrn == m_nk; m_wrn <= m_wrn + 1;
          m_st <= 3; m_lat <= int'($urandom_range(1, 6));
        end else if (bus.cmd == C_RD) begin
          ev.push_back({C_RD, 8'h00}); m_dout <= m_rd; m_st <= 3; m_lat <= int'($urandom_range(1, 6));
        end else if (bus.cmd == C_STOP) begin
          ev.push_back({C_STOP, 8'h00}); m_st <= 5; m_lat <= int'($urandom_range(1, 6));
        end
        4: m_st <= 2;
        default: m_st <= 0;
      endcase
    end
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (bus.wr) wr_cnt <= wr_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_nack"}, nack, 0);
    chk({p, "_tout"}, tout, 0);
    chk({p, "_rdata"}, rdata, 0);
    chk({p, "_wr"}, bus.wr, 0);
    chk({p, "_cmd"}, bus.cmd, 3'd7);
    chk({p, "_din"}, bus.din, 0);
  endtask
  // nk = index of the written byte the slave NACKs (values above 2 mean never)
  task automatic run_txn(input bit r, input logic [6:0] d, input logic [7:0] a, input logic [7:0] w,
                         input int nk, input logic [7:0] rd, input bit dbl);
    logic [10:0] exq[$];
    int base, dbase, n;
    base = ev.size(); dbase = done_cnt; m_nk = nk; m_rd = rd;
    exq.push_back({C_START, 8'h00});
    exq.push_back({C_WR, d, 1'b0});
    if (nk == 0) exq.push_back({C_STOP, 8'h00});
    else begin
      exq.push_back({C_WR, a});
      if (nk == 1) exq.push_back({C_STOP, 8'h00});
      else if (!r) begin
        exq.push_back({C_WR, w}); exq.push_back({C_STOP, 8'h00});
      end else begin
        exq.push_back({C_STOP, 8'h00}); exq.push_back({C_START, 8'h00}); exq.push_back({C_WR, d, 1'b1});
        if (nk == 2) exq.push_back({C_STOP, 8'h00});
        else begin
          exq.push_back({C_RD, 8'h00}); exq.push_back({C_STOP, 8'h00});
        end
      end
    end
    @(negedge clk); start = 1'b1; rw = r; dev = d; rg = a; wd = w;
    @(negedge clk); start = 1'b0; rw = 1'($urandom); dev = 7'($urandom); rg = 8'($urandom); wd = 8'($urandom);
    chk("busy_after_start", busy, 1);
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk); n++;
      start = dbl && n == 8;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("busy_low_at_done", busy, 0);
    chk("nack_err", nack, nk <= 2);
    chk("tout_err", tout, 0);
    if (r && nk > 2) exp_rdata = rd;
    chk("rdata", rdata, exp_rdata);
    repeat (20) @(negedge clk);
    chk("done_pulses", done_cnt - dbase, 1);
    chk("busy_idle", busy, 0);
    chk("n_events", ev.size() - base, exq.size());
    for (int i = 0; i < exq.size() && base + i < ev.size(); i++)
      chk($sformatf("event%0d", i), ev[base + i], exq[i]);
  endtask
  initial begin
    int n, base, wbase;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 9, 8'h00, 1'b0);
    run_txn(1'b1, 7'h50, 8'h10, 8'h00, 9, 8'h3C, 1'b0);
    run_txn(1'b0, 7'h50, 8'h10, 8'h77, 0, 8'h00, 1'b0);
    run_txn(1'b0, 7'h22, 8'h33, 8'h44, 9, 8'h00, 1'b1);
    base = ev.size(); m_nk = 9;
    @(negedge clk); start = 1'b1; rw = 1'b0; dev = 7'h11; rg = 8'h22; wd = 8'h33;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (ev.size() < base + 3 && n < 500) begin
      @(negedge clk); n++;
    end
    chk("reach_breg", ev.size() - base, 3);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    exp_rdata = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 7'h3A, 8'h5B, 8'hC6, 9, 8'h00, 1'b0);
    tie0 = 1'b1; wbase = wr_cnt;
    @(negedge clk); start = 1'b1; rw = 1'b0; dev = 7'h50;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk); n++;
    end
    chk("tmo_done", done, 1);
    chk("tmo_cycles", n, TMO);
    chk("tmo_tout", tout, 1);
    chk("tmo_nack", nack, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_rdata", rdata, exp_rdata);
    @(negedge clk);
    chk("tmo_wr_pulses", wr_cnt - wbase, 0);
    chk("tmo_cmd", bus.cmd, 3'd7);
    tie0 = 1'b0;
    repeat (16)
      run_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 5)), 8'($urandom), 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
